// File: rtl/transmitter_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : transmitter_bit_timer
// Brief    : UART TX bit-period timer: START/DATA/PARITY/STOP done strobes and
//            data-bit index. Optional macro TRANSMITTER_BIT_TIMER_HALF_STOP_EN
//            enables 1.5 stop bits (i_stop_bits = 2).
// Revision : 1.0 - initial release
// ============================================================================
module transmitter_bit_timer #(
  parameter int CNT_WIDTH              = 24,
  parameter int DEFAULT_CLOCKS_PER_BIT = 434,
  parameter int STOP_GUARD_CLOCKS      = 0
) (
  input  logic                 i_clock,
  input  logic                 i_resetL,
  input  logic                 i_state_is_START,
  input  logic                 i_state_is_DATA,
  input  logic                 i_state_is_PARITY,
  input  logic                 i_state_is_STOP,
  input  logic [CNT_WIDTH-1:0] i_clocks_per_bit,
  input  logic [3:0]           i_data_bits,
  input  logic [1:0]           i_stop_bits,
  output logic                 o_bit_done,
  output logic                 o_stop_done,
  output logic                 o_last_data_bit,
  output logic [3:0]           o_bit_index
);

  localparam int                   c_sum_w       = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_two     = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] c_default_cpb = CNT_WIDTH'(DEFAULT_CLOCKS_PER_BIT);
  localparam logic [c_sum_w-1:0]   c_guard       = c_sum_w'(STOP_GUARD_CLOCKS);
  localparam logic [c_sum_w-1:0]   c_rst_sum     = {2'b00, c_default_cpb} + c_guard;
  localparam logic [CNT_WIDTH-1:0] c_rst_stop    =
    (c_rst_sum[c_sum_w-1:CNT_WIDTH] != 2'b00) ? {CNT_WIDTH{1'b1}} : c_rst_sum[CNT_WIDTH-1:0];

  // One-hot phase encoding after priority resolution
  localparam logic [3:0] c_ph_none   = 4'b0000;
  localparam logic [3:0] c_ph_start  = 4'b0001;
  localparam logic [3:0] c_ph_data   = 4'b0010;
  localparam logic [3:0] c_ph_parity = 4'b0100;
  localparam logic [3:0] c_ph_stop   = 4'b1000;

  logic [CNT_WIDTH-1:0] r_count;
  logic [3:0]           r_bit_index;
  logic                 r_start_q;
  logic [3:0]           r_phase_q;
  logic [CNT_WIDTH-1:0] r_cpb_l;
  logic [3:0]           r_nbits_l;
  logic [CNT_WIDTH-1:0] r_stop_limit_l;

  logic [3:0]           w_phase;
  logic                 w_active;
  logic                 w_in_bit_phase;
  logic                 w_in_data;
  logic                 w_latch;
  logic [CNT_WIDTH-1:0] w_cpb_in;
  logic [3:0]           w_nbits_in;
  logic [c_sum_w-1:0]   w_stop_sum;
  logic [CNT_WIDTH-1:0] w_stop_in;
  logic [CNT_WIDTH-1:0] w_cpb;
  logic [3:0]           w_nbits;
  logic [CNT_WIDTH-1:0] w_stop_limit;
  logic [CNT_WIDTH-1:0] w_cnt;
  logic                 w_bit_done;
  logic                 w_stop_done;
  logic                 w_last_bit;

  always_comb begin
    w_phase = c_ph_none;
    if (i_state_is_STOP)        w_phase = c_ph_stop;
    else if (i_state_is_PARITY) w_phase = c_ph_parity;
    else if (i_state_is_DATA)   w_phase = c_ph_data;
    else if (i_state_is_START)  w_phase = c_ph_start;
  end

  assign w_active       = (w_phase != c_ph_none);
  assign w_in_data      = (w_phase == c_ph_data);
  assign w_in_bit_phase = (w_phase == c_ph_start) | w_in_data | (w_phase == c_ph_parity);

  // Config is sampled once on START entry; bypassed so the entry cycle sees it
  assign w_latch    = i_state_is_START & ~r_start_q;
  assign w_cpb_in   = (i_clocks_per_bit < c_cnt_two) ? c_default_cpb : i_clocks_per_bit;
  assign w_nbits_in = ((i_data_bits >= 4'd5) && (i_data_bits <= 4'd9)) ? i_data_bits : 4'd8;

  always_comb begin
    w_stop_sum = {2'b00, w_cpb_in} + c_guard;
    case (i_stop_bits)
      2'd1:    w_stop_sum = {2'b00, w_cpb_in} + {2'b00, w_cpb_in} + c_guard;
`ifdef TRANSMITTER_BIT_TIMER_HALF_STOP_EN
      2'd2:    w_stop_sum = {2'b00, w_cpb_in} + {3'b000, w_cpb_in[CNT_WIDTH-1:1]} + c_guard;
`endif
      default: w_stop_sum = {2'b00, w_cpb_in} + c_guard;
    endcase
  end

  assign w_stop_in = (w_stop_sum[c_sum_w-1:CNT_WIDTH] != 2'b00) ? {CNT_WIDTH{1'b1}}
                                                                : w_stop_sum[CNT_WIDTH-1:0];

  assign w_cpb        = w_latch ? w_cpb_in   : r_cpb_l;
  assign w_nbits      = w_latch ? w_nbits_in : r_nbits_l;
  assign w_stop_limit = w_latch ? w_stop_in  : r_stop_limit_l;

  // A phase change without a done strobe (abort) restarts the count at zero
  assign w_cnt       = (w_phase != r_phase_q) ? '0 : r_count;
  assign w_bit_done  = w_in_bit_phase & (w_cnt == (w_cpb - c_cnt_one));
  assign w_stop_done = (w_phase == c_ph_stop) & (w_cnt == (w_stop_limit - c_cnt_one));
  assign w_last_bit  = (r_bit_index == (w_nbits - 4'd1));

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      r_count        <= '0;
      r_bit_index    <= 4'd0;
      r_start_q      <= 1'b0;
      r_phase_q      <= c_ph_none;
      r_cpb_l        <= c_default_cpb;
      r_nbits_l      <= 4'd8;
      r_stop_limit_l <= c_rst_stop;
    end else begin
      r_start_q <= i_state_is_START;
      r_phase_q <= w_phase;

      if (w_latch) begin
        r_cpb_l        <= w_cpb_in;
        r_nbits_l      <= w_nbits_in;
        r_stop_limit_l <= w_stop_in;
      end

      if (!w_active || w_bit_done || w_stop_done) r_count <= '0;
      else                                        r_count <= w_cnt + c_cnt_one;

      if (!w_in_data)      r_bit_index <= 4'd0;
      else if (w_bit_done) r_bit_index <= w_last_bit ? 4'd0 : r_bit_index + 4'd1;
    end
  end

  assign o_bit_done      = w_bit_done;
  assign o_stop_done     = w_stop_done;
  assign o_last_data_bit = w_in_data & w_last_bit;
  assign o_bit_index     = r_bit_index;

endmodule
`default_nettype wire

// File: tb/tb_transmitter_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_transmitter_bit_timer
// Brief    : Directed self-checking bench for transmitter_bit_timer
//            (STOP_GUARD_CLOCKS = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_transmitter_bit_timer;

  localparam int CW    = 24;
  localparam int GUARD = 3;
`ifdef TRANSMITTER_BIT_TIMER_HALF_STOP_EN
  localparam int HALF_STOP_CLKS = 10 + 5 + GUARD;
`else
  localparam int HALF_STOP_CLKS = 10 + GUARD;
`endif

  logic          clk = 1'b0;
  logic          rst_l;
  logic          st_start, st_data, st_parity, st_stop;
  logic [CW-1:0] cpb;
  logic [3:0]    data_bits;
  logic [1:0]    stop_bits;
  logic          bit_done, stop_done, last_bit;
  logic [3:0]    bit_index;

  int n_tests = 0;
  int n_fail  = 0;

  transmitter_bit_timer #(
    .CNT_WIDTH              (CW),
    .DEFAULT_CLOCKS_PER_BIT (434),
    .STOP_GUARD_CLOCKS      (GUARD)
  ) dut (
    .i_clock           (clk),
    .i_resetL          (rst_l),
    .i_state_is_START  (st_start),
    .i_state_is_DATA   (st_data),
    .i_state_is_PARITY (st_parity),
    .i_state_is_STOP   (st_stop),
    .i_clocks_per_bit  (cpb),
    .i_data_bits       (data_bits),
    .i_stop_bits       (stop_bits),
    .o_bit_done        (bit_done),
    .o_stop_done       (stop_done),
    .o_last_data_bit   (last_bit),
    .o_bit_index       (bit_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input logic s, input logic d, input logic p, input logic t);
    st_start  = s;
    st_data   = d;
    st_parity = p;
    st_stop   = t;
  endtask

  initial begin
    // Reset state
    rst_l = 1'b0;
    flags(0, 0, 0, 0);
    cpb = 24'd10; data_bits = 4'd8; stop_bits = 2'd0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_bit_done", int'(bit_done), 0);
    chk("rst_stop_done", int'(stop_done), 0);
    chk("rst_last_bit", int'(last_bit), 0);
    chk("rst_bit_index", int'(bit_index), 0);
    rst_l = 1'b1;
    cyc();

    // START held, cpb = 10: done on cycles 10, 20, 30
    flags(1, 0, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("t1_bit_done", int'(bit_done), (k % 10 == 0) ? 1 : 0);
      chk("t1_index", int'(bit_index), 0);
      cyc();
    end

    // cpb = 4, 5 data bits: index 0..4 then wraps
    flags(0, 0, 0, 0); cpb = 24'd4; data_bits = 4'd5;
    cyc();
    flags(1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t2_start_done", int'(bit_done), (k == 4) ? 1 : 0);
      cyc();
    end
    flags(0, 1, 0, 0);
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      chk("t2_index", int'(bit_index), ((j - 1) / 4) % 5);
      chk("t2_bit_done", int'(bit_done), (j % 4 == 0) ? 1 : 0);
      chk("t2_last_bit", int'(last_bit), ((((j - 1) / 4) % 5) == 4) ? 1 : 0);
      cyc();
    end

    // 2 stop bits, cpb = 8, guard 3: stop_done at 19
    flags(0, 0, 0, 0); cpb = 24'd8; stop_bits = 2'd1;
    cyc();
    flags(1, 0, 0, 0);
    cyc();
    flags(0, 0, 0, 1);
    for (int j = 1; j <= 19; j++) begin
      @(negedge clk);
      chk("t3_stop_done", int'(stop_done), (j == 19) ? 1 : 0);
      chk("t3_bit_done", int'(bit_done), 0);
      cyc();
    end

    // Out-of-range config falls back to 434 / 8 bits; mid-DATA changes ignored
    flags(0, 0, 0, 0); cpb = 24'd1; data_bits = 4'd12; stop_bits = 2'd0;
    cyc();
    flags(1, 0, 0, 0);
    cyc();
    flags(0, 1, 0, 0);
    for (int j = 1; j <= 3473; j++) begin
      if (j == 3) begin
        cpb = 24'd6; data_bits = 4'd5;
      end
      @(negedge clk);
      chk("t4_bit_done", int'(bit_done), (j % 434 == 0) ? 1 : 0);
      chk("t4_index", int'(bit_index), ((j - 1) / 434) % 8);
      chk("t4_last_bit", int'(last_bit), ((((j - 1) / 434) % 8) == 7) ? 1 : 0);
      cyc();
    end

    // Asynchronous reset mid-DATA (index 1, count 5), then re-latch cpb = 6
    flags(0, 0, 0, 0); cpb = 24'd10; data_bits = 4'd8;
    cyc();
    flags(1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t5_start_done", int'(bit_done), (k == 10) ? 1 : 0);
      cyc();
    end
    flags(0, 1, 0, 0);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      chk("t5_index", int'(bit_index), (j - 1) / 10);
      chk("t5_bit_done", int'(bit_done), (j % 10 == 0) ? 1 : 0);
      if (j < 16) cyc();
    end
    #2;
    rst_l = 1'b0;
    #1;
    chk("t5_rst_index", int'(bit_index), 0);
    chk("t5_rst_bit_done", int'(bit_done), 0);
    chk("t5_rst_last_bit", int'(last_bit), 0);
    chk("t5_rst_stop_done", int'(stop_done), 0);
    flags(0, 0, 0, 0);
    cyc(); cyc();
    rst_l = 1'b1; cpb = 24'd6;
    flags(1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("t5_relatch_done", int'(bit_done), (k == 6) ? 1 : 0);
      cyc();
    end

    // 1.5 stop bits (macro) or 1 stop bit, cpb = 10, guard 3
    flags(0, 0, 0, 0); cpb = 24'd10; stop_bits = 2'd2;
    cyc();
    flags(1, 0, 0, 0);
    cyc();
    flags(0, 0, 0, 1);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      chk("t6_half_stop_done", int'(stop_done), (j == HALF_STOP_CLKS) ? 1 : 0);
      cyc();
    end

    // i_stop_bits = 3 is one stop bit in every build
    flags(0, 0, 0, 0); stop_bits = 2'd3;
    cyc();
    flags(1, 0, 0, 0);
    cyc();
    flags(0, 0, 0, 1);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      chk("t6_stop3_done", int'(stop_done), (j == 13) ? 1 : 0);
      cyc();
    end

    // STOP wins over DATA/PARITY: no bit_done, stop_done at cpb + guard = 7
    flags(0, 0, 0, 0); cpb = 24'd4;
    cyc();
    flags(1, 0, 0, 0);
    cyc();
    flags(0, 1, 1, 1);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk("t7_prio_bit_done", int'(bit_done), 0);
      chk("t7_prio_last_bit", int'(last_bit), 0);
      chk("t7_prio_stop_done", int'(stop_done), (j == 7) ? 1 : 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
